// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Brief    : Shared types and sizing for the RSA key-preparation stage.
// Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int RSA_WIDTH = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_key_prep_if.sv
`default_nettype none
// ============================================================================
// Module   : rsa_key_prep_if
// Brief    : Start/done handshake and key-material bus for rsa_key_prep.
// Revision : 1.0 - initial release
// ============================================================================
interface rsa_key_prep_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     p;
    logic [WIDTH-1:0]     q;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [2*WIDTH-1:0]   n;
    logic [2*WIDTH-1:0]   phi;

    modport master (output start, p, q, input busy, done, err, n, phi);
    modport slave  (input start, p, q, output busy, done, err, n, phi);
endinterface
`default_nettype wire

// File: rtl/rsa_key_prep_step.sv
`default_nettype none
// ============================================================================
// Module   : rsa_shift_add_step
// Brief    : One combinational shift-add multiply iteration for one lane.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_shift_add_step #(
    parameter int WIDTH = 128
) (
    input  wire logic [2*WIDTH-1:0] i_acc,
    input  wire logic [2*WIDTH-1:0] i_mcand,
    input  wire logic [WIDTH-1:0]   i_mplier,
    output logic      [2*WIDTH-1:0] o_acc,
    output logic      [2*WIDTH-1:0] o_mcand,
    output logic      [WIDTH-1:0]   o_mplier
);
    assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand  = i_mcand << 1;
    assign o_mplier = i_mplier >> 1;
endmodule
`default_nettype wire

// File: rtl/rsa_key_prep.sv
`default_nettype none
// ============================================================================
// Module   : rsa_key_prep
// Brief    : Iterative n = p*q and phi = (p-1)*(q-1) with start/done handshake.
//            Define RSA_KEY_PREP_EARLY_EXIT_EN to stop once both multipliers
//            are exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_key_prep
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     reset,
    rsa_key_prep_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int DW    = 2 * WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [DW-1:0]    r_mc_n;
    logic [DW-1:0]    r_mc_phi;
    logic [WIDTH-1:0] r_mp_n;
    logic [WIDTH-1:0] r_mp_phi;
    logic [DW-1:0]    r_acc_n;
    logic [DW-1:0]    r_acc_phi;
    logic [DW-1:0]    r_n;
    logic [DW-1:0]    r_phi;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_done;

    logic [DW-1:0]    w_acc_n;
    logic [DW-1:0]    w_acc_phi;
    logic [DW-1:0]    w_mc_n;
    logic [DW-1:0]    w_mc_phi;
    logic [WIDTH-1:0] w_mp_n;
    logic [WIDTH-1:0] w_mp_phi;
    logic             w_bad;
    logic             w_last;

    rsa_shift_add_step #(.WIDTH(WIDTH)) u_step_n (
        .i_acc    (r_acc_n),
        .i_mcand  (r_mc_n),
        .i_mplier (r_mp_n),
        .o_acc    (w_acc_n),
        .o_mcand  (w_mc_n),
        .o_mplier (w_mp_n)
    );

    rsa_shift_add_step #(.WIDTH(WIDTH)) u_step_phi (
        .i_acc    (r_acc_phi),
        .i_mcand  (r_mc_phi),
        .i_mplier (r_mp_phi),
        .o_acc    (w_acc_phi),
        .o_mcand  (w_mc_phi),
        .o_mplier (w_mp_phi)
    );

    assign w_bad = (r_p < WIDTH'(2)) || (r_q < WIDTH'(2));

`ifdef RSA_KEY_PREP_EARLY_EXIT_EN
    // Exit when the iteration now executing leaves no multiplier bits behind.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || ((w_mp_n == '0) && (w_mp_phi == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = w_bad ? ST_FIN : ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p       <= '0;
            r_q       <= '0;
            r_mc_n    <= '0;
            r_mc_phi  <= '0;
            r_mp_n    <= '0;
            r_mp_phi  <= '0;
            r_acc_n   <= '0;
            r_acc_phi <= '0;
            r_n       <= '0;
            r_phi     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Operands are latched here so the source may move on.
                    if (bus.start) begin
                        r_p   <= bus.p;
                        r_q   <= bus.q;
                        r_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_mc_n    <= DW'(r_p);
                    r_mc_phi  <= DW'(r_p - WIDTH'(1));
                    r_mp_n    <= r_q;
                    r_mp_phi  <= r_q - WIDTH'(1);
                    r_acc_n   <= '0;
                    r_acc_phi <= '0;
                    r_cnt     <= '0;
                    if (w_bad) begin
                        r_err <= 1'b1;
                        r_n   <= '0;
                        r_phi <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc_n   <= w_acc_n;
                    r_acc_phi <= w_acc_phi;
                    r_mc_n    <= w_mc_n;
                    r_mc_phi  <= w_mc_phi;
                    r_mp_n    <= w_mp_n;
                    r_mp_phi  <= w_mp_phi;
                    r_cnt     <= r_cnt + CNT_W'(1);
                end
                ST_FIN: begin
                    r_n    <= r_acc_n;
                    r_phi  <= r_acc_phi;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != ST_IDLE) || r_done;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.n    = r_n;
    assign bus.phi  = r_phi;

endmodule
`default_nettype wire
